// File: rtl/hilo_muldiv_sequencer_if.sv
// Start/operand request and HI/LO result bundle between the control FSM and the mul/div sequencer.
interface hilo_muldiv_sequencer_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 6
);
   logic             start;
   logic [1:0]       op;
   logic [XLEN-1:0]  src_a;
   logic [XLEN-1:0]  src_b;
   logic             busy;
   logic             done;
   logic             div_zero;
   logic             illegal_op;
   logic             hilo_write;
   logic [XLEN-1:0]  hi_out;
   logic [XLEN-1:0]  lo_out;
   logic [CNT_W-1:0] counter;

   modport master (
      output start, op, src_a, src_b,
      input  busy, done, div_zero, illegal_op, hilo_write, hi_out, lo_out, counter
   );

   modport slave (
      input  start, op, src_a, src_b,
      output busy, done, div_zero, illegal_op, hilo_write, hi_out, lo_out, counter
   );
endinterface

// File: rtl/hilo_muldiv_sequencer.sv
// Iterative shift-add multiply / restoring divide owning the HI/LO pair.
// Define MULDIV_UNSIGNED_EN to enable MULTU/DIVU; otherwise they report illegal_op.
module hilo_muldiv_sequencer #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic                    clock,
   input  logic                    reset,
   hilo_muldiv_sequencer_if.slave  bus
);
   localparam int unsigned AW = 2 * XLEN;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FIX, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic             neg_q, neg_d, neg_rem_q, neg_rem_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d;
   logic             div_zero_q, div_zero_d, illegal_q, illegal_d, write_q, write_d;
   logic [XLEN-1:0]  hi_q, hi_d, lo_q, lo_d;

   logic             is_div, op_signed, op_legal, neg_a, neg_b;
   logic [XLEN-1:0]  mag_a, mag_b;
   logic [XLEN:0]    mul_sum, div_shift, div_diff;
   logic [AW-1:0]    mul_next, div_next;

   // Operand decode and one iteration step of each datapath
   always_comb begin
      is_div = op_q[0];
`ifdef MULDIV_UNSIGNED_EN
      op_signed = ~op_q[1];
      op_legal  = 1'b1;
`else
      op_signed = 1'b1;
      op_legal  = ~op_q[1];
`endif
      neg_a = op_signed & a_q[XLEN-1];
      neg_b = op_signed & b_q[XLEN-1];
      mag_a = neg_a ? (XLEN'(0) - a_q) : a_q;
      mag_b = neg_b ? (XLEN'(0) - b_q) : b_q;

      // Multiply: acc = {partial, multiplier}; add multiplicand on LSB, then shift right
      mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, a_q};
      mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]}
                          : {1'b0, acc_q[AW-1:XLEN], acc_q[XLEN-1:1]};

      // Divide: acc = {remainder, quotient}; shift left, keep difference if non-negative
      div_shift = acc_q[AW-1:XLEN-1];
      div_diff  = div_shift - {1'b0, b_q};
      div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      a_d        = a_q;
      b_d        = b_q;
      acc_d      = acc_q;
      neg_d      = neg_q;
      neg_rem_d  = neg_rem_q;
      cnt_d      = cnt_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = 1'b0;
      illegal_d  = 1'b0;
      write_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_LOAD;
               op_d    = bus.op;
               a_d     = bus.src_a;
               b_d     = bus.src_b;
            end
         end
         S_LOAD: begin
            a_d       = mag_a;
            b_d       = mag_b;
            neg_d     = neg_a ^ neg_b;
            neg_rem_d = neg_a;
            cnt_d     = '0;
            acc_d     = is_div ? {XLEN'(0), mag_a} : {XLEN'(0), mag_b};
            if (!op_legal) begin
               state_d   = S_DONE;
               illegal_d = 1'b1;
            end else if (is_div && (b_q == XLEN'(0))) begin
               state_d    = S_DONE;
               div_zero_d = 1'b1;
            end else begin
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            acc_d = is_div ? div_next : mul_next;
            if (cnt_q == CNT_W'(XLEN - 1)) begin
               cnt_d   = '0;
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FIX: begin
            // Remainder follows the dividend sign; product/quotient follow sign xor
            if (is_div) begin
               acc_d = {neg_rem_q ? (XLEN'(0) - acc_q[AW-1:XLEN]) : acc_q[AW-1:XLEN],
                        neg_q     ? (XLEN'(0) - acc_q[XLEN-1:0]) : acc_q[XLEN-1:0]};
            end else begin
               acc_d = neg_q ? (AW'(0) - acc_q) : acc_q;
            end
            write_d = 1'b1;
            state_d = S_DONE;
         end
         S_DONE: begin
            if (write_q) begin
               hi_d = acc_q[AW-1:XLEN];
               lo_d = acc_q[XLEN-1:0];
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         acc_q      <= '0;
         neg_q      <= 1'b0;
         neg_rem_q  <= 1'b0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
         illegal_q  <= 1'b0;
         write_q    <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         a_q        <= a_d;
         b_q        <= b_d;
         acc_q      <= acc_d;
         neg_q      <= neg_d;
         neg_rem_q  <= neg_rem_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
         illegal_q  <= illegal_d;
         write_q    <= write_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.div_zero   = div_zero_q;
   assign bus.illegal_op = illegal_q;
   assign bus.hilo_write = write_q;
   assign bus.hi_out     = hi_q;
   assign bus.lo_out     = lo_q;
   assign bus.counter    = cnt_q;
endmodule

// File: tb/tb_hilo_muldiv_sequencer.sv
// Directed plus random bench for hilo_muldiv_sequencer against an arithmetic HI/LO reference.
module tb_hilo_muldiv_sequencer;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   hilo_muldiv_sequencer_if bus ();

   hilo_muldiv_sequencer dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operation semantics
   task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic wr, output logic dz, output logic ill,
                        output logic [31:0] nhi, output logic [31:0] nlo);
      int          sa, sb, sq, sr;
      longint      sp;
      logic [63:0] up;
      sa = a; sb = b;
      wr = 1'b0; dz = 1'b0; ill = 1'b0; nhi = exp_hi; nlo = exp_lo;
`ifndef MULDIV_UNSIGNED_EN
      if (op[1]) begin
         ill = 1'b1;
         return;
      end
`endif
      if (op[0] && b == 32'd0) begin
         dz = 1'b1;
         return;
      end
      wr = 1'b1;
      case (op)
         2'b00: begin
            sp = longint'(sa) * longint'(sb);
            nhi = sp[63:32]; nlo = sp[31:0];
         end
         2'b01: begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               nlo = 32'h8000_0000; nhi = 32'd0;
            end else begin
               sq = sa / sb; sr = sa % sb;
               nlo = sq; nhi = sr;
            end
         end
         2'b10: begin
            up = {32'd0, a} * {32'd0, b};
            nhi = up[63:32]; nlo = up[31:0];
         end
         default: begin
            nlo = a / b; nhi = a % b;
         end
      endcase
   endtask

   // Issue one op from the current IDLE cycle and follow it to the commit edge
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int restart_n);
      logic        wr, dz, ill;
      logic [31:0] nhi, nlo;
      int          n, lat;
      model(op, a, b, wr, dz, ill, nhi, nlo);
      lat = (dz || ill) ? 1 : 34;
      bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.op = 2'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
      check("busy_after_accept", 64'(bus.busy), 64'(1));
      n = 0;
      while (!bus.done && n < 60) begin
         @(posedge clk); #1;
         n++;
         if (n == restart_n) begin
            bus.start = 1'b1; bus.op = 2'($urandom); bus.src_a = $urandom; bus.src_b = $urandom;
         end else begin
            bus.start = 1'b0;
         end
         check("busy_during_op", 64'(bus.busy), 64'(1));
         check("counter", 64'(bus.counter),
               64'((lat == 34 && n >= 1 && n <= 32) ? n - 1 : 0));
      end
      bus.start = 1'b0;
      check("latency", 64'(n), 64'(lat));
      check("done", 64'(bus.done), 64'(1));
      check("div_zero", 64'(bus.div_zero), 64'(dz));
      check("illegal_op", 64'(bus.illegal_op), 64'(ill));
      check("hilo_write", 64'(bus.hilo_write), 64'(wr));
      check("hi_before_commit", 64'(bus.hi_out), 64'(exp_hi));
      check("lo_before_commit", 64'(bus.lo_out), 64'(exp_lo));
      @(posedge clk); #1;
      exp_hi = nhi; exp_lo = nlo;
      check("hi_after_commit", 64'(bus.hi_out), 64'(exp_hi));
      check("lo_after_commit", 64'(bus.lo_out), 64'(exp_lo));
      check("busy_idle", 64'(bus.busy), 64'(0));
      check("done_cleared", 64'(bus.done), 64'(0));
      check("write_cleared", 64'(bus.hilo_write), 64'(0));
   endtask

   initial begin
      int n;
      logic [31:0] ra, rb;
      bus.start = 1'b0; bus.op = 2'b00; bus.src_a = '0; bus.src_b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(bus.busy), 64'(0));
      check("rst_done", 64'(bus.done), 64'(0));
      check("rst_hi", 64'(bus.hi_out), 64'(0));
      check("rst_lo", 64'(bus.lo_out), 64'(0));
      check("rst_counter", 64'(bus.counter), 64'(0));
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(2'b00, 32'd7, 32'hFFFF_FFFD, -1);
      run_op(2'b01, 32'hFFFF_FFF9, 32'd2, -1);
      run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, -1);
      run_op(2'b01, 32'd5, 32'd0, -1);
      run_op(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 11);
      run_op(2'b10, 32'hFFFF_FFFF, 32'd2, -1);
      run_op(2'b11, 32'hFFFF_FFFF, 32'd7, -1);
      run_op(2'b11, 32'd9, 32'd0, -1);
      run_op(2'b01, 32'hFFFF_FF9C, 32'd7, -1);

      // Abort mid-RUN with reset; HI/LO clear immediately
      bus.start = 1'b1; bus.op = 2'b00; bus.src_a = 32'd1234; bus.src_b = 32'd5678;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0;
      while (bus.counter != 6'd20 && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      check("reach_run_20", 64'(n), 64'(21));
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(bus.busy), 64'(0));
      check("abort_hi", 64'(bus.hi_out), 64'(0));
      check("abort_lo", 64'(bus.lo_out), 64'(0));
      check("abort_counter", 64'(bus.counter), 64'(0));
      exp_hi = '0; exp_lo = '0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_op(2'b00, 32'hFFFF_FFF0, 32'h0000_0100, -1);

      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 5))
            0:       ra = 32'h8000_0000;
            1:       ra = $urandom_range(0, 100);
            default: ra = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0:       rb = 32'd0;
            1:       rb = $urandom_range(1, 15);
            2:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         run_op(2'($urandom_range(0, 3)), ra, rb, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
